// File: rtl/alu_issue_stage.sv
// ID/EX issue register for the ALU: decodes opcode/funct into ALU_control, picks
// the B operand, forwards EX/MEM and MEM/WB results and registers everything for EX.
module alu_issue_stage #(
  parameter int WORD     = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic [15:0]         imm,
  input  logic [REG_ADDR-1:0] rs_addr,
  input  logic [REG_ADDR-1:0] rt_addr,
  input  logic [WORD-1:0]     rs_data,
  input  logic [WORD-1:0]     rt_data,
  input  logic                exmem_regwrite,
  input  logic [REG_ADDR-1:0] exmem_rd,
  input  logic [WORD-1:0]     exmem_result,
  input  logic                memwb_regwrite,
  input  logic [REG_ADDR-1:0] memwb_rd,
  input  logic [WORD-1:0]     memwb_result,
  output logic                ex_valid,
  output logic [WORD-1:0]     a,
  output logic [WORD-1:0]     b,
  output logic [3:0]          ALU_control,
  output logic                illegal
);

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SUB     = 4'b0110,
    ALU_SLT     = 4'b0111,
    ALU_ILLEGAL = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    B_RT,
    B_SEXT,
    B_ZEXT
  } b_src_e;

  alu_op_e        alu_op;
  b_src_e         b_src;
  logic           dec_illegal;
  logic [WORD-1:0] a_fwd, rt_fwd, b_sel;

  logic                ex_valid_q, ex_valid_d;
  logic [WORD-1:0]     a_q, a_d;
  logic [WORD-1:0]     b_q, b_d;
  logic [3:0]          alu_ctrl_q, alu_ctrl_d;
  logic                illegal_q, illegal_d;

  // The nearer producer (EX/MEM) holds the newer value; $zero is never forwarded.
  function automatic logic [WORD-1:0] forward(
    input logic [REG_ADDR-1:0] addr,
    input logic [WORD-1:0]     rf_data,
    input logic                em_we,
    input logic [REG_ADDR-1:0] em_rd,
    input logic [WORD-1:0]     em_res,
    input logic                mw_we,
    input logic [REG_ADDR-1:0] mw_rd,
    input logic [WORD-1:0]     mw_res
  );
    if (addr == '0)                   return rf_data;
    else if (em_we && em_rd == addr)  return em_res;
    else if (mw_we && mw_rd == addr)  return mw_res;
    else                              return rf_data;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    alu_op      = ALU_ILLEGAL;
    b_src       = B_RT;
    dec_illegal = 1'b0;
    unique case (opcode)
      6'b000000: begin
        unique case (funct)
          6'b100000, 6'b100001: alu_op = ALU_ADD;
          6'b100010, 6'b100011: alu_op = ALU_SUB;
          6'b100100:            alu_op = ALU_AND;
          6'b100101:            alu_op = ALU_OR;
          6'b101010:            alu_op = ALU_SLT;
          default:              dec_illegal = 1'b1;
        endcase
      end
      6'b001000, 6'b001001: begin alu_op = ALU_ADD; b_src = B_SEXT; end
      6'b001010:            begin alu_op = ALU_SLT; b_src = B_SEXT; end
      6'b001100:            begin alu_op = ALU_AND; b_src = B_ZEXT; end
      6'b001101:            begin alu_op = ALU_OR;  b_src = B_ZEXT; end
      6'b100011, 6'b101011: begin alu_op = ALU_ADD; b_src = B_SEXT; end
      6'b000100:            alu_op = ALU_SUB;
      default:              dec_illegal = 1'b1;
    endcase
    if (dec_illegal) alu_op = ALU_ILLEGAL;
  end

  always_comb begin
    a_fwd  = forward(rs_addr, rs_data, exmem_regwrite, exmem_rd, exmem_result,
                     memwb_regwrite, memwb_rd, memwb_result);
    rt_fwd = forward(rt_addr, rt_data, exmem_regwrite, exmem_rd, exmem_result,
                     memwb_regwrite, memwb_rd, memwb_result);
    unique case (b_src)
      B_SEXT:  b_sel = {{(WORD-16){imm[15]}}, imm};
      B_ZEXT:  b_sel = {{(WORD-16){1'b0}}, imm};
      default: b_sel = rt_fwd;
    endcase
  end

  // Flush beats stall beats capture; an empty ID slot captures as a bubble.
  always_comb begin
    ex_valid_d = ex_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_ctrl_d = alu_ctrl_q;
    illegal_d  = illegal_q;
    if (flush || (!stall && !in_valid)) begin
      ex_valid_d = 1'b0;
      a_d        = '0;
      b_d        = '0;
      alu_ctrl_d = 4'b0000;
      illegal_d  = 1'b0;
    end else if (!stall) begin
      ex_valid_d = 1'b1;
      a_d        = a_fwd;
      b_d        = b_sel;
      alu_ctrl_d = alu_op;
      illegal_d  = dec_illegal;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      ex_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      alu_ctrl_q <= 4'b0000;
      illegal_q  <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_ctrl_q <= alu_ctrl_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign a           = a_q;
  assign b           = b_q;
  assign ALU_control = alu_ctrl_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: table of decode/forwarding vectors with a
// scoreboard queue, plus hand sequences for async reset, stall and flush.
module tb_alu_issue_stage;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        il;
  } out_t;

  typedef struct {
    logic        in_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        em_we;
    logic [4:0]  em_rd;
    logic [31:0] em_res;
    logic        mw_we;
    logic [4:0]  mw_rd;
    logic [31:0] mw_res;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid;
  logic [5:0]  opcode, funct;
  logic [15:0] imm;
  logic [4:0]  rs_addr, rt_addr, exmem_rd, memwb_rd;
  logic [31:0] rs_data, rt_data, exmem_result, memwb_result;
  logic        exmem_regwrite, memwb_regwrite;
  logic        ex_valid, illegal;
  logic [31:0] a, b;
  logic [3:0]  alu_control;

  int checks = 0;
  int errors = 0;
  out_t exp_q[$];
  vec_t vecs[$];

  alu_issue_stage #(.WORD(32), .REG_ADDR(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .opcode(opcode), .funct(funct), .imm(imm), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .a(a), .b(b), .ALU_control(alu_control), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic out_t mko(input logic v, input logic [31:0] ea, input logic [31:0] eb,
                               input logic [3:0] c, input logic il);
    out_t o;
    o.v = v; o.a = ea; o.b = eb; o.ctrl = c; o.il = il;
    return o;
  endfunction

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] im,
                              input logic [4:0] rs, input logic [31:0] rsd,
                              input logic [4:0] rt, input logic [31:0] rtd,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input logic [3:0] c, input logic il);
    vec_t t;
    t.in_valid = 1'b1; t.opcode = op; t.funct = fn; t.imm = im;
    t.rs_addr = rs; t.rs_data = rsd; t.rt_addr = rt; t.rt_data = rtd;
    t.em_we = 1'b0; t.em_rd = 5'd0; t.em_res = 32'd0;
    t.mw_we = 1'b0; t.mw_rd = 5'd0; t.mw_res = 32'd0;
    t.exp = mko(1'b1, ea, eb, c, il);
    return t;
  endfunction

  task automatic apply(input vec_t t);
    in_valid = t.in_valid; opcode = t.opcode; funct = t.funct; imm = t.imm;
    rs_addr = t.rs_addr; rt_addr = t.rt_addr; rs_data = t.rs_data; rt_data = t.rt_data;
    exmem_regwrite = t.em_we; exmem_rd = t.em_rd; exmem_result = t.em_res;
    memwb_regwrite = t.mw_we; memwb_rd = t.mw_rd; memwb_result = t.mw_res;
  endtask

  task automatic compare(input string tag);
    out_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty, got valid %b", tag, ex_valid);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_valid"},   32'(ex_valid),    32'(e.v));
    check({tag, "_a"},       a,                e.a);
    check({tag, "_b"},       b,                e.b);
    check({tag, "_ctrl"},    32'(alu_control), 32'(e.ctrl));
    check({tag, "_illegal"}, 32'(illegal),     32'(e.il));
  endtask

  // Drive one ID-stage input at the falling edge, expect it after the next rising edge.
  task automatic step(input vec_t t, input out_t e, input string tag);
    @(negedge clk);
    apply(t);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    vec_t t;
    out_t bubble;
    out_t held;
    bubble = mko(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0);

    // R-type decode
    vecs.push_back(mk(6'h00, 6'h20, 16'h0000, 5'd3,  32'd5,   5'd4,  32'd7,  32'd5,   32'd7,  4'b0010, 1'b0));
    vecs.push_back(mk(6'h00, 6'h21, 16'h0000, 5'd1,  32'd9,   5'd2,  32'd3,  32'd9,   32'd3,  4'b0010, 1'b0));
    vecs.push_back(mk(6'h00, 6'h22, 16'h0000, 5'd10, 32'd100, 5'd11, 32'd30, 32'd100, 32'd30, 4'b0110, 1'b0));
    vecs.push_back(mk(6'h00, 6'h23, 16'h0000, 5'd10, 32'd1,   5'd11, 32'd2,  32'd1,   32'd2,  4'b0110, 1'b0));
    vecs.push_back(mk(6'h00, 6'h24, 16'h0000, 5'd12, 32'hF0,  5'd13, 32'h3C, 32'hF0,  32'h3C, 4'b0000, 1'b0));
    vecs.push_back(mk(6'h00, 6'h25, 16'h0000, 5'd12, 32'hA,   5'd13, 32'h5,  32'hA,   32'h5,  4'b0001, 1'b0));
    vecs.push_back(mk(6'h00, 6'h2A, 16'h0000, 5'd14, 32'd4,   5'd15, 32'd6,  32'd4,   32'd6,  4'b0111, 1'b0));
    // Immediates: sign vs zero extension
    vecs.push_back(mk(6'h08, 6'h00, 16'hFFFF, 5'd1, 32'd100, 5'd2, 32'd55, 32'd100, 32'hFFFFFFFF, 4'b0010, 1'b0));
    vecs.push_back(mk(6'h09, 6'h00, 16'h7FFF, 5'd1, 32'd1,   5'd2, 32'd55, 32'd1,   32'h00007FFF, 4'b0010, 1'b0));
    vecs.push_back(mk(6'h0A, 6'h00, 16'h8000, 5'd1, 32'd2,   5'd2, 32'd55, 32'd2,   32'hFFFF8000, 4'b0111, 1'b0));
    vecs.push_back(mk(6'h0C, 6'h00, 16'h8001, 5'd1, 32'd3,   5'd2, 32'd55, 32'd3,   32'h00008001, 4'b0000, 1'b0));
    vecs.push_back(mk(6'h0D, 6'h00, 16'hFFFF, 5'd1, 32'd4,   5'd2, 32'd55, 32'd4,   32'h0000FFFF, 4'b0001, 1'b0));
    vecs.push_back(mk(6'h23, 6'h00, 16'h0004, 5'd29, 32'h1000, 5'd2, 32'd55, 32'h1000, 32'h00000004, 4'b0010, 1'b0));
    vecs.push_back(mk(6'h2B, 6'h00, 16'hFFFC, 5'd29, 32'h1000, 5'd2, 32'd55, 32'h1000, 32'hFFFFFFFC, 4'b0010, 1'b0));
    vecs.push_back(mk(6'h04, 6'h00, 16'h1234, 5'd5, 32'd9, 5'd6, 32'd8, 32'd9, 32'd8, 4'b0110, 1'b0));
    // Illegal opcode and funct, then a legal add clears illegal
    vecs.push_back(mk(6'h3F, 6'h20, 16'h0000, 5'd7, 32'hAA, 5'd8, 32'hBB, 32'hAA, 32'hBB, 4'b1111, 1'b1));
    vecs.push_back(mk(6'h00, 6'h20, 16'h0000, 5'd3, 32'd5,  5'd4, 32'd7,  32'd5,  32'd7,  4'b0010, 1'b0));
    vecs.push_back(mk(6'h00, 6'h00, 16'h0000, 5'd7, 32'h11, 5'd8, 32'h22, 32'h11, 32'h22, 4'b1111, 1'b1));
    // Forwarding: EX/MEM beats MEM/WB
    t = mk(6'h00, 6'h20, 16'h0000, 5'd8, 32'd99, 5'd4, 32'd7, 32'd11, 32'd7, 4'b0010, 1'b0);
    t.em_we = 1'b1; t.em_rd = 5'd8; t.em_res = 32'd11;
    t.mw_we = 1'b1; t.mw_rd = 5'd8; t.mw_res = 32'd22;
    vecs.push_back(t);
    t.em_we = 1'b0; t.exp.a = 32'd22;
    vecs.push_back(t);
    // $zero never forwarded
    t = mk(6'h00, 6'h20, 16'h0000, 5'd0, 32'h33, 5'd4, 32'd7, 32'h33, 32'd7, 4'b0010, 1'b0);
    t.em_we = 1'b1; t.em_rd = 5'd0; t.em_res = 32'd11;
    t.mw_we = 1'b1; t.mw_rd = 5'd0; t.mw_res = 32'd22;
    vecs.push_back(t);
    // rt path forwarding from MEM/WB
    t = mk(6'h00, 6'h20, 16'h0000, 5'd3, 32'd5, 5'd9, 32'd1, 32'd5, 32'd44, 4'b0010, 1'b0);
    t.mw_we = 1'b1; t.mw_rd = 5'd9; t.mw_res = 32'd44;
    vecs.push_back(t);
    // Immediate B ignores forwarding even though rt matches
    t = mk(6'h08, 6'h00, 16'h0005, 5'd8, 32'd99, 5'd8, 32'd77, 32'd11, 32'd5, 4'b0010, 1'b0);
    t.em_we = 1'b1; t.em_rd = 5'd8; t.em_res = 32'd11;
    vecs.push_back(t);
    // Empty ID slot captures a bubble
    t = mk(6'h00, 6'h20, 16'h0000, 5'd3, 32'd5, 5'd4, 32'd7, 32'd0, 32'd0, 4'b0000, 1'b0);
    t.in_valid = 1'b0; t.exp = bubble;
    vecs.push_back(t);

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    apply(mk(6'h00, 6'h00, 16'h0000, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 4'b0000, 1'b0));
    in_valid = 1'b0;
    #1;
    check("reset_valid", 32'(ex_valid), 32'd0);
    check("reset_a", a, 32'd0);
    check("reset_b", b, 32'd0);
    check("reset_ctrl", 32'(alu_control), 32'd0);
    check("reset_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) step(vecs[i], vecs[i].exp, $sformatf("vec%0d", i));

    // Asynchronous reset mid-stream, no clock edge involved
    step(vecs[0], vecs[0].exp, "pre_reset");
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", 32'(ex_valid), 32'd0);
    check("async_a", a, 32'd0);
    check("async_b", b, 32'd0);
    check("async_ctrl", 32'(alu_control), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Stall for two edges with fresh ID input, then stall+flush together
    step(vecs[0], vecs[0].exp, "pre_stall");
    held = vecs[0].exp;
    stall = 1'b1;
    step(vecs[2], held, "stall1");
    step(vecs[7], held, "stall2");
    flush = 1'b1;
    step(vecs[2], bubble, "stall_flush");
    stall = 1'b0; flush = 1'b0;
    step(vecs[11], vecs[11].exp, "post_flush");
    flush = 1'b1;
    step(vecs[11], bubble, "flush_only");
    flush = 1'b0;

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
